// File: rtl/fft_frame_ctrl_if.sv
// Stream, memory-address and AGU control bundle of the FFT frame sequencer.
// master = controller side, slave = source/sink/AGU/memory side.
interface fft_frame_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  ld_we;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic                  agu_run;
    logic                  agu_done;
    logic                  agu_row;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_bank;
    logic                  out_valid;
    logic                  out_ready;
    logic                  frame_done;
    logic                  timeout;
    logic                  busy;

    modport master (
        input  in_valid, agu_done, agu_row, out_ready,
        output in_ready, ld_we, ld_addr, agu_run, rd_addr, rd_bank,
               out_valid, frame_done, timeout, busy
    );

    modport slave (
        output in_valid, agu_done, agu_row, out_ready,
        input  in_ready, ld_we, ld_addr, agu_run, rd_addr, rd_bank,
               out_valid, frame_done, timeout, busy
    );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the in-place radix-2 FFT: load a frame into bank 0,
// run the AGU under a watchdog, then stream results out of the final bank.
module fft_frame_ctrl #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                clk,
    input  logic                rst,
    fft_frame_ctrl_if.master    ctrl_io
);
    localparam int unsigned     WDOG_W   = 16;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;
    localparam logic [WDOG_W-1:0]     WD_LAST  = WDOG_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_RUN    = 2'd2,
        S_UNLOAD = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [WDOG_W-1:0]       wdog_q, wdog_d;
    logic                    agu_run_q, agu_run_d;
    logic                    rd_bank_q, rd_bank_d;
    logic                    frame_done_q, frame_done_d;
    logic                    timeout_q, timeout_d;
    logic                    in_acc;
    logic                    out_xfer;
    logic                    cnt_last;

    assign cnt_last = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a done in the same cycle as watchdog expiry wins
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_acc) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (in_acc && cnt_last) state_d = S_RUN;
            end
            S_RUN: begin
                if (ctrl_io.agu_done)     state_d = S_UNLOAD;
                else if (wdog_q == WD_LAST) state_d = S_IDLE;
            end
            S_UNLOAD: begin
                if (out_xfer && cnt_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Decoded handshakes and next values of the registered datapath
    always_comb begin
        ctrl_io.in_ready  = ((state_q == S_IDLE) || (state_q == S_LOAD)) && !rst;
        ctrl_io.out_valid = (state_q == S_UNLOAD);
        ctrl_io.busy      = (state_q != S_IDLE);
        ctrl_io.ld_we     = ctrl_io.in_valid & ctrl_io.in_ready;
        in_acc            = ctrl_io.in_valid & ctrl_io.in_ready;
        out_xfer          = ctrl_io.out_valid & ctrl_io.out_ready;

        cnt_d        = cnt_q;
        wdog_d       = wdog_q;
        agu_run_d    = agu_run_q;
        rd_bank_d    = rd_bank_q;
        frame_done_d = 1'b0;
        timeout_d    = timeout_q;

        case (state_q)
            S_IDLE, S_LOAD: begin
                if (in_acc) begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                    if ((state_q == S_LOAD) && cnt_last) begin
                        agu_run_d = 1'b1;
                        wdog_d    = '0;
                    end
                end
            end
            S_RUN: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (ctrl_io.agu_done) begin
                    rd_bank_d = ctrl_io.agu_row;
                    agu_run_d = 1'b0;
                end else if (wdog_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    agu_run_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            S_UNLOAD: begin
                if (out_xfer) begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                    if (cnt_last) frame_done_d = 1'b1;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Registered datapath; reset drops agu_run immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            wdog_q       <= '0;
            agu_run_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            wdog_q       <= wdog_d;
            agu_run_q    <= agu_run_d;
            rd_bank_q    <= rd_bank_d;
            frame_done_q <= frame_done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign ctrl_io.ld_addr    = cnt_q;
    assign ctrl_io.rd_addr    = cnt_q;
    assign ctrl_io.agu_run    = agu_run_q;
    assign ctrl_io.rd_bank    = rd_bank_q;
    assign ctrl_io.frame_done = frame_done_q;
    assign ctrl_io.timeout    = timeout_q;
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed-plus-random bench for fft_frame_ctrl; expectations come from a
// frame-level model (sample/result indices, cycle budgets) held here.
module tb_fft_frame_ctrl;
    localparam int unsigned AW = 5;
    localparam int unsigned N  = 1 << AW;
    localparam int unsigned TO = 200;

    logic clk;
    logic rst;
    int   checks = 0;
    int   passed = 0;
    bit   fd_exp = 1'b0;

    fft_frame_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    fft_frame_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_io (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk_a(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One frame in; mode 0 = back-to-back, 1 = in_valid toggling, 2 = random gaps
    task automatic load_frame(input int mode);
        for (int i = 0; i < int'(N); i++) begin
            int gaps;
            gaps = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (gaps) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                #1;
                chk_b("idle_in_ready", bus.in_ready, 1'b1);
                chk_b("idle_ld_we", bus.ld_we, 1'b0);
                chk_a("idle_ld_addr_hold", bus.ld_addr, AW'(i));
                chk_b("idle_busy", bus.busy, i != 0);
                chk_b("idle_frame_done", bus.frame_done, fd_exp);
                fd_exp = 1'b0;
            end
            @(negedge clk);
            bus.in_valid = 1'b1;
            #1;
            chk_b("acc_in_ready", bus.in_ready, 1'b1);
            chk_b("acc_ld_we", bus.ld_we, 1'b1);
            chk_a("acc_ld_addr", bus.ld_addr, AW'(i));
            chk_b("acc_busy", bus.busy, i != 0);
            chk_b("acc_agu_run", bus.agu_run, 1'b0);
            chk_b("acc_frame_done", bus.frame_done, fd_exp);
            fd_exp = 1'b0;
        end
        @(posedge clk);
        #1;
        chk_b("run_entry_agu_run", bus.agu_run, 1'b1);
        chk_b("run_entry_in_ready", bus.in_ready, 1'b0);
        chk_b("run_entry_ld_we", bus.ld_we, 1'b0);
        chk_b("run_entry_out_valid", bus.out_valid, 1'b0);
    endtask

    // AGU stand-in: done with the given phase bit after lat RUN cycles
    task automatic run_frame(input int lat, input bit row);
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom);
            bus.agu_done = 1'b0;
            #1;
            chk_b("run_agu_run", bus.agu_run, 1'b1);
            chk_b("run_in_ready", bus.in_ready, 1'b0);
            chk_b("run_ld_we", bus.ld_we, 1'b0);
            chk_b("run_out_valid", bus.out_valid, 1'b0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.agu_done = 1'b1;
        bus.agu_row  = row;
        #1;
        chk_b("done_cycle_agu_run", bus.agu_run, 1'b1);
        @(posedge clk);
        #1;
        chk_b("post_done_agu_run", bus.agu_run, 1'b0);
        chk_b("post_done_out_valid", bus.out_valid, 1'b1);
        chk_a("post_done_rd_addr", bus.rd_addr, AW'(0));
        chk_b("post_done_rd_bank", bus.rd_bank, row);
        bus.agu_done = 1'b0;
        bus.agu_row  = ~row;
    endtask

    task automatic run_timeout();
        for (int k = 1; k <= int'(TO); k++) begin
            @(negedge clk);
            bus.in_valid = (k < int'(TO)) ? 1'($urandom) : 1'b0;
            #1;
            chk_b("wd_busy", bus.busy, 1'b1);
            chk_b("wd_agu_run", bus.agu_run, 1'b1);
            chk_b("wd_timeout_low", bus.timeout, 1'b0);
            chk_b("wd_ld_we", bus.ld_we, 1'b0);
        end
        @(posedge clk);
        #1;
        chk_b("to_timeout", bus.timeout, 1'b1);
        chk_b("to_agu_run", bus.agu_run, 1'b0);
        chk_b("to_busy", bus.busy, 1'b0);
        chk_b("to_frame_done", bus.frame_done, 1'b0);
        chk_b("to_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        #1;
        chk_b("to_no_frame_done", bus.frame_done, 1'b0);
        chk_b("to_timeout_sticky", bus.timeout, 1'b1);
        chk_a("to_ld_addr", bus.ld_addr, AW'(0));
    endtask

    // Results out; optional fixed 3-cycle stall, random stalls, reset point
    task automatic unload(input int stall_at, input bit rnd, input int rst_at,
                          input bit bank, input bit to_exp);
        for (int i = 0; i < int'(N); i++) begin
            int stalls;
            stalls = (i == stall_at) ? 3 : (rnd && $urandom_range(0, 3) == 0) ? 1 : 0;
            repeat (stalls) begin
                @(negedge clk);
                bus.out_ready = 1'b0;
                #1;
                chk_b("stall_out_valid", bus.out_valid, 1'b1);
                chk_a("stall_rd_addr_hold", bus.rd_addr, AW'(i));
                chk_b("stall_rd_bank", bus.rd_bank, bank);
                chk_b("stall_frame_done", bus.frame_done, 1'b0);
            end
            if (i == rst_at) begin
                @(negedge clk);
                bus.in_valid = 1'b1;
                #1;
                chk_a("pre_rst_rd_addr", bus.rd_addr, AW'(i));
                rst = 1'b1;
                #1;
                chk_b("rst_in_ready", bus.in_ready, 1'b0);
                chk_b("rst_ld_we", bus.ld_we, 1'b0);
                chk_b("rst_busy", bus.busy, 1'b0);
                chk_b("rst_out_valid", bus.out_valid, 1'b0);
                chk_b("rst_agu_run", bus.agu_run, 1'b0);
                chk_b("rst_rd_bank", bus.rd_bank, 1'b0);
                chk_b("rst_timeout", bus.timeout, 1'b0);
                chk_b("rst_frame_done", bus.frame_done, 1'b0);
                chk_a("rst_rd_addr", bus.rd_addr, AW'(0));
                return;
            end
            @(negedge clk);
            bus.out_ready = 1'b1;
            #1;
            chk_b("xfer_out_valid", bus.out_valid, 1'b1);
            chk_a("xfer_rd_addr", bus.rd_addr, AW'(i));
            chk_b("xfer_rd_bank", bus.rd_bank, bank);
            chk_b("xfer_in_ready", bus.in_ready, 1'b0);
            chk_b("xfer_timeout", bus.timeout, to_exp);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk_b("end_frame_done", bus.frame_done, 1'b1);
        chk_b("end_busy", bus.busy, 1'b0);
        chk_b("end_in_ready", bus.in_ready, 1'b1);
        chk_b("end_out_valid", bus.out_valid, 1'b0);
        chk_b("end_timeout", bus.timeout, to_exp);
        fd_exp = 1'b1;
    endtask

    initial begin
        bit r;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.agu_done  = 1'b0;
        bus.agu_row   = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        chk_b("reset_in_ready", bus.in_ready, 1'b0);
        chk_b("reset_ld_we", bus.ld_we, 1'b0);
        chk_b("reset_busy", bus.busy, 1'b0);
        chk_b("reset_agu_run", bus.agu_run, 1'b0);
        chk_b("reset_out_valid", bus.out_valid, 1'b0);
        chk_b("reset_frame_done", bus.frame_done, 1'b0);
        chk_b("reset_timeout", bus.timeout, 1'b0);
        chk_b("reset_rd_bank", bus.rd_bank, 1'b0);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk_b("release_in_ready", bus.in_ready, 1'b1);

        // Contiguous frame, AGU done at 161 with phase 1, stall at result 7
        load_frame(0);
        run_frame(161, 1'b1);
        unload(7, 1'b0, -1, 1'b1, 1'b0);

        // Back-to-back gapped frame
        load_frame(1);
        run_frame(int'($urandom_range(1, 190)), 1'b1);
        unload(-1, 1'b1, -1, 1'b1, 1'b0);

        // Watchdog abort, then a normal frame with the flag still set
        load_frame(2);
        bus.agu_done = 1'b0;
        run_timeout();
        r = 1'($urandom);
        load_frame(0);
        run_frame(int'($urandom_range(1, 190)), r);
        unload(-1, 1'b1, -1, r, 1'b1);

        // Reset in the middle of unloading, then a fresh full frame
        load_frame(2);
        run_frame(int'($urandom_range(1, 190)), 1'b1);
        unload(-1, 1'b0, 12, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        fd_exp       = 1'b0;
        #1;
        chk_b("rerelease_in_ready", bus.in_ready, 1'b1);
        chk_a("rerelease_ld_addr", bus.ld_addr, AW'(0));
        r = 1'($urandom);
        load_frame(0);
        run_frame(int'($urandom_range(1, 190)), r);
        unload(-1, 1'b1, -1, r, 1'b0);
        @(posedge clk);
        #1;
        chk_b("frame_done_one_cycle", bus.frame_done, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
